// File: rtl/fifo_pkg.sv
// Shared defaults and width helper for the parametrised synchronous FIFO.
package fifo_pkg;

    localparam int FIFO_DATA_W = 8;
    localparam int FIFO_DEPTH  = 16;

    // Ceiling log2 usable in constant expressions; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer handshake bundle for sync_fifo_param; the FIFO takes the slave side.
interface sync_fifo_param_if
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int DEPTH  = FIFO_DEPTH
);
    localparam int CNT_W = clog2(DEPTH) + 1;

    logic              wr_en;
    logic [DATA_W-1:0] data_in;
    logic              rd_en;
    logic              clr_err;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              data_full;
    logic              data_empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_en, data_in, rd_en, clr_err,
        input  data_out, data_valid, data_full, data_empty,
               almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr_en, data_in, rd_en, clr_err,
        output data_out, data_valid, data_full, data_empty,
               almost_full, almost_empty, count, overflow, underflow
    );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W register array: synchronous write port, asynchronous read port.
module fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO: pointers, occupancy count, threshold and sticky error flags,
// with registered or show-ahead read data selected by SHOW_AHEAD.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W     = FIFO_DATA_W,
    parameter int DEPTH      = FIFO_DEPTH,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter int SHOW_AHEAD = 0
) (
    input  logic            clk,
    input  logic            rst,
    sync_fifo_param_if.slave bus
);

    localparam int AW    = clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) ||
        (AE_LEVEL >= AF_LEVEL) || (AF_LEVEL > DEPTH)) begin : g_bad_cfg
        $error("sync_fifo_param: DEPTH must be a power of two >= 2 and AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dvalid_q, dvalid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic              full;
    logic              empty;
    logic              rd_acc;
    logic              wr_acc;
    logic [DATA_W-1:0] mem_rdata;

    assign full   = (count_q == CNT_W'(DEPTH));
    assign empty  = (count_q == '0);
    assign rd_acc = bus.rd_en && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
    assign wr_acc = bus.wr_en && (!full || rd_acc);

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk    (clk),
        .we     (wr_acc),
        .waddr  (wr_ptr_q),
        .wdata  (bus.data_in),
        .raddr  (rd_ptr_q),
        .rdata  (mem_rdata)
    );

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        dout_d      = dout_q;
        dvalid_d    = 1'b0;
        overflow_d  = (overflow_q  && !bus.clr_err) || (bus.wr_en && !wr_acc);
        underflow_d = (underflow_q && !bus.clr_err) || (bus.rd_en && !rd_acc);

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_acc && !rd_acc) begin
            count_d = count_q + CNT_W'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CNT_W'(1);
        end

        if ((SHOW_AHEAD == 0) && rd_acc) begin
            dout_d   = mem_rdata;
            dvalid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dout_q      <= '0;
            dvalid_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            dout_q      <= dout_d;
            dvalid_q    <= dvalid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Show-ahead output is forced to zero while empty so reset and idle read back as 0.
    assign bus.data_out     = (SHOW_AHEAD != 0) ? (empty ? '0 : mem_rdata) : dout_q;
    assign bus.data_valid   = (SHOW_AHEAD != 0) ? !empty : dvalid_q;
    assign bus.data_full    = full;
    assign bus.data_empty   = empty;
    assign bus.almost_full  = (count_q >= CNT_W'(AF_LEVEL));
    assign bus.almost_empty = (count_q <= CNT_W'(AE_LEVEL));
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: registered-read and show-ahead instances.
module tb_sync_fifo_param;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sync_fifo_param_if #(.DATA_W(8), .DEPTH(16)) if0 ();
    sync_fifo_param_if #(.DATA_W(8), .DEPTH(16)) if1 ();

    sync_fifo_param #(
        .DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .SHOW_AHEAD(0)
    ) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    sync_fifo_param #(
        .DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .SHOW_AHEAD(1)
    ) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    int nerr = 0;
    int nchk = 0;
    logic [7:0] model_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle0();
        if0.wr_en   = 1'b0;
        if0.rd_en   = 1'b0;
        if0.clr_err = 1'b0;
        if0.data_in = 8'h00;
    endtask

    initial begin
        logic       wr, rd, exp_rd, exp_wr;
        logic [7:0] din, exp_d;
        int         nw;

        idle0();
        if1.wr_en = 1'b0; if1.rd_en = 1'b0; if1.clr_err = 1'b0; if1.data_in = 8'h00;

        // Reset values
        #23;
        chk("rst_count",  if0.count, 0);
        chk("rst_empty",  if0.data_empty, 1);
        chk("rst_aempty", if0.almost_empty, 1);
        chk("rst_full",   if0.data_full, 0);
        chk("rst_afull",  if0.almost_full, 0);
        chk("rst_dout",   if0.data_out, 0);
        chk("rst_valid",  if0.data_valid, 0);
        chk("rst_ovf",    if0.overflow, 0);
        chk("rst_udf",    if0.underflow, 0);
        chk("rst_sa_dout", if1.data_out, 0);
        chk("rst_sa_valid", if1.data_valid, 0);
        rst = 1'b1;
        tick();

        // Fill 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            if0.wr_en = 1'b1; if0.data_in = 8'(i);
            tick();
            chk("fill_count",  if0.count, i + 1);
            chk("fill_afull",  if0.almost_full, (i + 1 >= 14) ? 1 : 0);
            chk("fill_aempty", if0.almost_empty, (i + 1 <= 2) ? 1 : 0);
            chk("fill_full",   if0.data_full, (i == 15) ? 1 : 0);
        end
        if0.data_in = 8'hEE;
        tick();
        chk("ovf_set",   if0.overflow, 1);
        chk("ovf_count", if0.count, 16);
        idle0();

        // Drain with registered reads
        for (int i = 0; i < 16; i++) begin
            if0.rd_en = 1'b1;
            tick();
            chk("drain_data",  if0.data_out, i);
            chk("drain_valid", if0.data_valid, 1);
            chk("drain_count", if0.count, 15 - i);
        end
        chk("drain_empty", if0.data_empty, 1);
        chk("drain_udf_pre", if0.underflow, 0);
        tick();
        chk("udf_set",   if0.underflow, 1);
        chk("udf_hold",  if0.data_out, 8'h0F);
        chk("udf_valid", if0.data_valid, 0);
        idle0();
        if0.clr_err = 1'b1;
        tick();
        chk("clr_ovf", if0.overflow, 0);
        chk("clr_udf", if0.underflow, 0);
        idle0();

        // Full FIFO with simultaneous read and write
        for (int i = 0; i < 16; i++) begin
            if0.wr_en = 1'b1; if0.data_in = 8'(8'h10 + i);
            tick();
        end
        chk("sim_full_pre", if0.data_full, 1);
        if0.wr_en = 1'b1; if0.rd_en = 1'b1; if0.data_in = 8'hA5;
        tick();
        chk("sim_count", if0.count, 16);
        chk("sim_ovf",   if0.overflow, 0);
        chk("sim_data",  if0.data_out, 8'h10);
        idle0();
        for (int i = 1; i < 16; i++) begin
            if0.rd_en = 1'b1;
            tick();
            chk("sim_drain", if0.data_out, 8'h10 + i);
        end
        tick();
        chk("sim_a5",       if0.data_out, 8'hA5);
        chk("sim_a5_empty", if0.data_empty, 1);

        // Empty FIFO with simultaneous read and write
        if0.wr_en = 1'b1; if0.rd_en = 1'b1; if0.data_in = 8'h77;
        tick();
        chk("emp_sim_count", if0.count, 1);
        chk("emp_sim_udf",   if0.underflow, 1);
        chk("emp_sim_valid", if0.data_valid, 0);
        idle0();
        if0.rd_en = 1'b1; if0.clr_err = 1'b1;
        tick();
        chk("emp_sim_data", if0.data_out, 8'h77);
        chk("emp_sim_clr",  if0.underflow, 0);
        idle0();

        // 40 writes interleaved with reads across pointer wrap
        nw = 0;
        model_q.delete();
        for (int cyc = 0; cyc < 200 && (nw < 40 || model_q.size() > 0); cyc++) begin
            wr  = (nw < 40);
            rd  = (nw >= 40) || (cyc % 4 != 0);
            din = 8'(8'h40 + nw);
            if0.wr_en = wr; if0.rd_en = rd; if0.data_in = din;
            exp_rd = rd && (model_q.size() > 0);
            exp_wr = wr && (model_q.size() < 16 || exp_rd);
            exp_d  = 8'h00;
            if (exp_rd) exp_d = model_q.pop_front();
            if (exp_wr) begin
                model_q.push_back(din);
                nw++;
            end
            tick();
            chk("wrap_count", if0.count, model_q.size());
            chk("wrap_valid", if0.data_valid, exp_rd);
            if (exp_rd) chk("wrap_data", if0.data_out, exp_d);
        end
        chk("wrap_empty", if0.data_empty, 1);
        chk("wrap_ovf",   if0.overflow, 0);
        idle0();

        // Sticky flags: clr_err coinciding with a new error keeps the flag set
        if0.rd_en = 1'b1;
        tick();
        chk("stk_udf", if0.underflow, 1);
        if0.clr_err = 1'b1;
        tick();
        chk("stk_udf_clr_collide", if0.underflow, 1);
        idle0();
        if0.clr_err = 1'b1;
        tick();
        chk("stk_udf_clr", if0.underflow, 0);
        idle0();

        // Asynchronous reset mid-burst at count 9
        for (int i = 0; i < 10; i++) begin
            if0.wr_en = 1'b1; if0.data_in = 8'(8'h90 + i);
            tick();
        end
        if0.wr_en = 1'b0; if0.rd_en = 1'b1;
        tick();
        chk("mid_count", if0.count, 9);
        chk("mid_dout",  if0.data_out, 8'h90);
        if0.rd_en = 1'b0; if0.wr_en = 1'b1; if0.data_in = 8'h9A;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_count",  if0.count, 0);
        chk("arst_empty",  if0.data_empty, 1);
        chk("arst_aempty", if0.almost_empty, 1);
        chk("arst_afull",  if0.almost_full, 0);
        chk("arst_dout",   if0.data_out, 0);
        chk("arst_valid",  if0.data_valid, 0);
        idle0();
        @(negedge clk);
        rst = 1'b1;
        tick();
        if0.wr_en = 1'b1; if0.data_in = 8'hE1;
        tick();
        chk("post_count", if0.count, 1);
        idle0();
        if0.rd_en = 1'b1;
        tick();
        chk("post_data",  if0.data_out, 8'hE1);
        chk("post_empty", if0.data_empty, 1);
        idle0();

        // Show-ahead instance
        if1.wr_en = 1'b1; if1.data_in = 8'h3C;
        tick();
        chk("sa_data",  if1.data_out, 8'h3C);
        chk("sa_empty", if1.data_empty, 0);
        chk("sa_valid", if1.data_valid, 1);
        if1.data_in = 8'h5D;
        tick();
        chk("sa_head_hold", if1.data_out, 8'h3C);
        if1.wr_en = 1'b0; if1.rd_en = 1'b1;
        tick();
        chk("sa_next",  if1.data_out, 8'h5D);
        chk("sa_count", if1.count, 1);
        tick();
        chk("sa_pop_empty", if1.data_empty, 1);
        chk("sa_pop_valid", if1.data_valid, 0);
        chk("sa_pop_count", if1.count, 0);
        if1.rd_en = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised synchronous FIFO: next-generation single-clock buffer with configurable data width and depth, a full DEPTH-entry capacity, almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags and a selectable show-ahead (first-word-fall-through) read mode. It sits between a producer and a consumer in the same clock domain, e.g. between a byte-stream source and a packet parser.

## Interface
- DATA_W, 8, data width in bits
- DEPTH, 16, number of entries; power of two, >= 2
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL
- SHOW_AHEAD, 0, 0 = registered read, 1 = first-word-fall-through
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- wr_en  in  1  write request
- data_in  in  DATA_W  write data
- rd_en  in  1  read request (pop in SHOW_AHEAD=1)
- clr_err  in  1  synchronous clear of overflow/underflow
- data_out  out  DATA_W  read data
- data_valid  out  1  data_out holds newly read word (SHOW_AHEAD=0); equals !data_empty (SHOW_AHEAD=1)
- data_full  out  1  count == DEPTH
- data_empty  out  1  count == 0
- almost_full  out  1  threshold flag
- almost_empty  out  1  threshold flag
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write requested while not accepted
- underflow  out  1  sticky: read requested while empty

## Operation
- rd_acc = rd_en && !data_empty; wr_acc = wr_en && (!data_full || rd_acc).
- wr_acc: mem[wr_ptr] <= data_in, wr_ptr increments. rd_acc: rd_ptr increments.
- Full with rd_en and wr_en both high: both accepted, count stays DEPTH, no overflow.
- Empty with both high: write accepted, read rejected, count -> 1, underflow set.
- count: +1 on wr_acc only, -1 on rd_acc only, unchanged on both/neither.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally; count carries the extra bit that distinguishes full from empty.
- SHOW_AHEAD=0: on rd_acc, data_out <= mem[rd_ptr] and data_valid <= 1; otherwise data_out holds and data_valid <= 0.
- SHOW_AHEAD=1: data_out = mem[rd_ptr] combinationally; it is meaningful whenever data_empty = 0. rd_acc advances to the next entry.
- overflow <= 1 when wr_en && !wr_acc; underflow <= 1 when rd_en && !rd_acc. Both stay set until clr_err = 1 or reset. If clr_err and a new error occur in the same cycle, the flag is set.
- All flags decode from registered count, so they are glitch-free.

## Timing
- Reset (rst low, any time, asynchronous): pointers = 0, count = 0, data_out = 0, data_valid = 0, overflow = underflow = 0, data_empty = 1, almost_empty = 1, data_full = almost_full = 0.
- Memory contents are not reset. Any transfer in flight at reset is discarded. Reset release is synchronised externally by the instantiating block.
- Write at edge k: count and flags update after edge k. SHOW_AHEAD=1: data_out valid after edge k (1-cycle write-to-read latency).
- SHOW_AHEAD=0: rd_en sampled at edge k, so data_out and data_valid appear after edge k (1 cycle). Back-to-back reads give one word per cycle.
- Sustained simultaneous read+write gives one word per cycle in each direction at any occupancy.

## Structure
- Shared package fifo_pkg: default parameter values (FIFO_DATA_W = 8, FIFO_DEPTH = 16) and a function clog2 for pointer and count widths.
- One sub-module, fifo_mem: DEPTH x DATA_W register array with a synchronous write port and an asynchronous read port.
- The top module holds the pointers, count, flags and the read-mode logic.
- Elaboration check: DEPTH is a power of two and AE_LEVEL < AF_LEVEL <= DEPTH.

## Test plan
- Reset then 16 writes 0x00..0x0F (DEPTH=16) -> count 16, data_full=1, almost_full asserted at count 14; 17th write sets overflow, count stays 16.
- Drain 16 reads (SHOW_AHEAD=0) -> data_out 0x00..0x0F, each one cycle after rd_en with data_valid=1; data_empty=1 afterwards; an extra read sets underflow, data_out holds 0x0F.
- Full FIFO, rd_en=wr_en=1 with data_in=0xA5 -> count stays 16, no overflow; 0xA5 emerges after the 15 older words.
- SHOW_AHEAD=1: write 0x3C into an empty FIFO -> data_out=0x3C and data_empty=0 the cycle after the write edge; rd_en pops it, data_empty=1.
- 40 writes interleaved with reads across pointer wrap -> output order matches input order; clr_err clears the sticky flags.
- Assert rst mid-burst at count 9 -> all outputs take their reset values immediately without a clock edge; a subsequent write/read returns the new data.
